move_stack_sequencer: RTL

Sits directly upstream of the board updater and is the only block that drives its move inputs.
- Accepts "do move" and "undo move" commands from the search controller.
- Keeps a LIFO history of applied moves.
- Presents each move (forward, or popped with undo asserted) to the board updater as one-hot square masks plus piece, castling and en-passant codes, with a one-cycle update strobe.
- Tracks side-to-move across plies.

---
 rtl/chess_pkg.sv | 47 ++++
 rtl/square_decoder.sv | 12 +
 rtl/move_stack_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared chess move encodings for the move stack sequencer.
// Holds the one-hot piece codes, castling and en-passant codes (with their
// NONE values), move-entry field widths, the packed stack entry and the
// sequencer FSM state type.
package chess_pkg;

    localparam int SQ_W     = 6;
    localparam int PIECE_W  = 6;
    localparam int CASTLE_W = 3;
    localparam int EP_W     = 5;
    localparam int ENTRY_W  = SQ_W + SQ_W + PIECE_W + PIECE_W + CASTLE_W + EP_W;

    localparam logic [PIECE_W-1:0] PIECE_NONE   = 6'b000000;
    localparam logic [PIECE_W-1:0] PIECE_PAWN   = 6'b000001;
    localparam logic [PIECE_W-1:0] PIECE_ROOK   = 6'b000010;
    localparam logic [PIECE_W-1:0] PIECE_KNIGHT = 6'b000100;
    localparam logic [PIECE_W-1:0] PIECE_BISHOP = 6'b001000;
    localparam logic [PIECE_W-1:0] PIECE_QUEEN  = 6'b010000;
    localparam logic [PIECE_W-1:0] PIECE_KING   = 6'b100000;

    localparam logic [CASTLE_W-1:0] CASTLE_NONE  = 3'b001;
    localparam logic [CASTLE_W-1:0] CASTLE_QUEEN = 3'b010;
    localparam logic [CASTLE_W-1:0] CASTLE_KING  = 3'b100;

    localparam logic [EP_W-1:0] EP_NONE = 5'b00001;
    localparam logic [EP_W-1:0] EP_UL   = 5'b00010;
    localparam logic [EP_W-1:0] EP_UR   = 5'b00100;
    localparam logic [EP_W-1:0] EP_DL   = 5'b01000;
    localparam logic [EP_W-1:0] EP_DR   = 5'b10000;

    typedef struct packed {
        logic [SQ_W-1:0]     fromSq;
        logic [SQ_W-1:0]     toSq;
        logic [PIECE_W-1:0]  moving;
        logic [PIECE_W-1:0]  captured;
        logic [CASTLE_W-1:0] castling;
        logic [EP_W-1:0]     enpassant;
    } moveEntry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } seqState_t;

endpackage

// File: rtl/square_decoder.sv
// Square index to one-hot board mask, purely combinational.
// Ports:
//   idx  - square index 0..63
//   mask - 64-bit mask with only bit idx set
module square_decoder (
    input  logic [5:0]  idx,
    output logic [63:0] mask
);

    assign mask = 64'h1 << idx;

endmodule

// File: rtl/move_stack_sequencer.sv
// Move stack sequencer: accepts do/undo commands, keeps a LIFO history of
// applied moves and presents each move to the board updater with a one-cycle
// strobe, then waits UPD_LATENCY cycles before signalling completion.
// Ports:
//   clk, clear          - clock, async active-high reset
//   engine_color        - side to move after reset
//   cmd_*               - command handshake and move fields
//   upd_*               - registered move presented to the board updater
//   done, err           - completion pulse and reject flag
//   depth, side_to_move - stack occupancy and current side
//
// state  | meaning
// IDLE   | ready for a command
// ISSUE  | upd_enable strobe cycle
// SETTLE | waiting UPD_LATENCY cycles for the updater
// DONE   | done pulse (err set for rejected commands)
import chess_pkg::*;

module move_stack_sequencer #(
    parameter int DEPTH       = 16,
    parameter int UPD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       engine_color,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_undo,
    input  logic [5:0]                 cmd_from,
    input  logic [5:0]                 cmd_to,
    input  logic [5:0]                 cmd_moving,
    input  logic [5:0]                 cmd_captured,
    input  logic [2:0]                 cmd_castling,
    input  logic [4:0]                 cmd_enpassant,
    output logic [63:0]                upd_initial_pos,
    output logic [63:0]                upd_moved_pos,
    output logic [5:0]                 upd_moving,
    output logic [5:0]                 upd_captured,
    output logic [2:0]                 upd_castling,
    output logic [4:0]                 upd_enpassant,
    output logic                       upd_undo,
    output logic                       upd_color,
    output logic                       upd_enable,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       side_to_move
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(UPD_LATENCY + 1);

    seqState_t  state;
    logic [CW-1:0] settleCnt;
    moveEntry_t stack [DEPTH];

    moveEntry_t cmdEntry;
    moveEntry_t topEntry;
    moveEntry_t selEntry;
    logic [DW-1:0] depthM1;
    logic [IW-1:0] wrIdx;
    logic [IW-1:0] rdIdx;
    logic isFull;
    logic isEmpty;
    logic [63:0] srcMask;
    logic [63:0] dstMask;

    assign cmd_ready = (state == IDLE);

    assign cmdEntry = '{fromSq:    cmd_from,
                        toSq:      cmd_to,
                        moving:    cmd_moving,
                        captured:  cmd_captured,
                        castling:  cmd_castling,
                        enpassant: cmd_enpassant};

    assign depthM1  = depth - DW'(1);
    assign wrIdx    = depth[IW-1:0];
    assign rdIdx    = depthM1[IW-1:0];
    assign topEntry = stack[rdIdx];
    assign isFull   = (depth == DW'(DEPTH));
    assign isEmpty  = (depth == '0);

    // An undo replays the stored entry; the command fields are ignored.
    assign selEntry = cmd_undo ? topEntry : cmdEntry;

    square_decoder uSrcDecoder (
        .idx  (selEntry.fromSq),
        .mask (srcMask)
    );

    square_decoder uDstDecoder (
        .idx  (selEntry.toSq),
        .mask (dstMask)
    );

    // Stack storage carries no reset; only entries below depth are ever read.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid && !cmd_undo && !isFull) begin
            stack[wrIdx] <= cmdEntry;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state           <= IDLE;
            settleCnt       <= '0;
            depth           <= '0;
            side_to_move    <= engine_color;
            upd_initial_pos <= '0;
            upd_moved_pos   <= '0;
            upd_moving      <= '0;
            upd_captured    <= '0;
            upd_castling    <= CASTLE_NONE;
            upd_enpassant   <= EP_NONE;
            upd_undo        <= 1'b0;
            upd_color       <= 1'b0;
            upd_enable      <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_undo ? isEmpty : isFull) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            upd_initial_pos <= srcMask;
                            upd_moved_pos   <= dstMask;
                            upd_moving      <= selEntry.moving;
                            upd_captured    <= selEntry.captured;
                            upd_castling    <= selEntry.castling;
                            upd_enpassant   <= selEntry.enpassant;
                            upd_undo        <= cmd_undo;
                            // The undone move was made by the side not on move now.
                            upd_color       <= cmd_undo ? ~side_to_move : side_to_move;
                            side_to_move    <= ~side_to_move;
                            depth           <= cmd_undo ? depthM1 : depth + DW'(1);
                            upd_enable      <= 1'b1;
                            state           <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    upd_enable <= 1'b0;
                    settleCnt  <= CW'(UPD_LATENCY);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt == CW'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        settleCnt <= settleCnt - CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
